// File: rtl/evt_mailbox_pkg.sv
// Shared constants for the event mailbox: endpoint word width, count_out layout, select width.
// Optional counter path is enabled with EVT_MAILBOX_COUNT_EN.
package evt_mailbox_pkg;

   localparam int MAX_EVT = 16;
   localparam int EP_W    = 16;
   localparam int OVF_BIT = 15;
   localparam int SEL_W   = 4;

   typedef logic [EP_W-1:0] ep_word_t;

endpackage

// File: rtl/evt_mailbox_chan.sv
// One mailbox channel: sticky pend bit, first-occurrence irq pulse and, with
// EVT_MAILBOX_COUNT_EN, a saturating counter with overflow flag and snapshot shadow.
module evt_mailbox_chan #(
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           evt,
   input  logic           ack,
   input  logic           snap,
   output logic           pend,
   output logic           pend_nxt,
   output logic           irq,
   output logic [CNT_W:0] shadow
);

   logic pend_q, pend_d;
   logic irq_q, irq_d;

   // An ack+evt collision opens a new epoch, so it notifies even though pend stays high.
   always_comb begin
      pend_d = pend_q;
      if (evt) begin
         pend_d = 1'b1;
      end else if (ack) begin
         pend_d = 1'b0;
      end
      irq_d = evt & (~pend_q | ack);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_q <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         irq_q  <= irq_d;
      end
   end

   assign pend     = pend_q;
   assign pend_nxt = pend_d;
   assign irq      = irq_q;

`ifdef EVT_MAILBOX_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W:0]   shadow_q, shadow_d;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (evt && ack) begin
         cnt_d = CNT_W'(1);
         ovf_d = 1'b0;
      end else if (ack) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (evt) begin
         if (&cnt_q) begin
            ovf_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      // Snapshot captures the post-update value so a same-cycle event is included.
      shadow_d = snap ? {ovf_d, cnt_d} : shadow_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         shadow_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         shadow_q <= shadow_d;
      end
   end

   assign shadow = shadow_q;
`else
   logic unused_snap;
   assign unused_snap = snap;
   assign shadow      = '0;
`endif

endmodule

// File: rtl/evt_mailbox.sv
// Event mailbox top: N_EVT channels, pending/irq padding, any_pend and the registered
// count_out select mux (count path present only with EVT_MAILBOX_COUNT_EN).
import evt_mailbox_pkg::*;

module evt_mailbox #(
   parameter int N_EVT = 16,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [MAX_EVT-1:0] evt_in,
   input  logic [MAX_EVT-1:0] ack_trig,
   input  logic               snap_trig,
   input  logic [SEL_W-1:0]   sel,
   output logic [EP_W-1:0]    pend_out,
   output logic [EP_W-1:0]    count_out,
   output logic [EP_W-1:0]    irq_trig,
   output logic               any_pend
);

   logic [N_EVT-1:0]          pend_w, pend_nxt_w, irq_w;
   logic [N_EVT-1:0][CNT_W:0] shadow_w;
   logic                      any_pend_q, any_pend_d;

   for (genvar i = 0; i < N_EVT; i++) begin : g_chan
      evt_mailbox_chan #(.CNT_W(CNT_W)) u_chan (
         .clk      (clk),
         .reset_n  (reset_n),
         .evt      (evt_in[i]),
         .ack      (ack_trig[i]),
         .snap     (snap_trig),
         .pend     (pend_w[i]),
         .pend_nxt (pend_nxt_w[i]),
         .irq      (irq_w[i]),
         .shadow   (shadow_w[i])
      );
   end

   // Channel inputs above N_EVT have no channel behind them.
   logic unused_in;
   assign unused_in = ^{evt_in, ack_trig};

   always_comb begin
      any_pend_d = |pend_nxt_w;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         any_pend_q <= 1'b0;
      end else begin
         any_pend_q <= any_pend_d;
      end
   end

   assign pend_out = EP_W'(pend_w);
   assign irq_trig = EP_W'(irq_w);
   assign any_pend = any_pend_q;

`ifdef EVT_MAILBOX_COUNT_EN
   ep_word_t count_q, count_d;

   // Out-of-range selects fall through to zero because no loop iteration matches.
   always_comb begin
      count_d = '0;
      for (int i = 0; i < N_EVT; i++) begin
         if (sel == SEL_W'(i)) begin
            count_d[OVF_BIT]     = shadow_w[i][CNT_W];
            count_d[CNT_W-1:0]   = shadow_w[i][CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_out = count_q;
`else
   logic unused_cnt;
   assign unused_cnt = ^{sel, shadow_w};
   assign count_out  = '0;
`endif

endmodule
